// File: rtl/lm_seq_8x8_mul.sv
// Sequential 8x8 unsigned multiplier that shares one external 4x4 multiplier across
// four nibble partial products. The accumulated sum saturates to 16 bits.
module lm_seq_8x8_mul #(
  parameter bit SKIP_LL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p
);

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t      state, state_nxt, start_st;
  logic [7:0]  a_r, b_r;
  logic [16:0] acc;
  logic [16:0] term;
  logic        accept;

  // The approximate core can over-estimate, so the 17-bit sum may exceed 16 bits.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign out_p     = sat16(acc);

  always_comb begin
    start_st = SKIP_LL ? PP1 : PP0;
    if ((in_a == 8'd0) || (in_b == 8'd0)) start_st = DONE;
  end

  always_comb begin
    state_nxt = state;
    mul_a     = 4'd0;
    mul_b     = 4'd0;
    term      = 17'd0;
    case (state)
      IDLE: if (accept) state_nxt = start_st;
      PP0: begin
        mul_a     = a_r[3:0];
        mul_b     = b_r[3:0];
        term      = {9'd0, mul_r};
        state_nxt = PP1;
      end
      PP1: begin
        mul_a     = a_r[7:4];
        mul_b     = b_r[3:0];
        term      = {5'd0, mul_r, 4'd0};
        state_nxt = PP2;
      end
      PP2: begin
        mul_a     = a_r[3:0];
        mul_b     = b_r[7:4];
        term      = {5'd0, mul_r, 4'd0};
        state_nxt = PP3;
      end
      PP3: begin
        mul_a     = a_r[7:4];
        mul_b     = b_r[7:4];
        term      = {1'b0, mul_r, 8'd0};
        state_nxt = DONE;
      end
      DONE: begin
        // Retiring a product and accepting the next pair can share one edge.
        if (out_ready) state_nxt = accept ? start_st : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 8'd0;
      b_r <= 8'd0;
      acc <= 17'd0;
    end else if (accept) begin
      a_r <= in_a;
      b_r <= in_b;
      acc <= 17'd0;
    end else if ((state == PP0) || (state == PP1) || (state == PP2) || (state == PP3)) begin
      acc <= acc + term;
    end
  end

endmodule

// File: tb/tb_lm_seq_8x8_mul.sv
// Directed bench for lm_seq_8x8_mul: one full-product instance and one truncating
// instance, each driven by a behavioural 4x4 multiplier model.
module tb_lm_seq_8x8_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        force_ff = 1'b0;

  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_a = 8'd0, in_b = 8'd0;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_r;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_p;

  logic        s_in_valid = 1'b0, s_in_ready;
  logic [7:0]  s_in_a = 8'd0, s_in_b = 8'd0;
  logic [3:0]  s_mul_a, s_mul_b;
  logic [7:0]  s_mul_r;
  logic        s_out_valid, s_out_ready = 1'b1;
  logic [15:0] s_out_p;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mul_r   = force_ff ? 8'hFF : ({4'd0, mul_a} * {4'd0, mul_b});
  assign s_mul_r = {4'd0, s_mul_a} * {4'd0, s_mul_b};

  lm_seq_8x8_mul #(.SKIP_LL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  lm_seq_8x8_mul #(.SKIP_LL(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_r(s_mul_r),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_p(s_out_p)
  );

  // Present an operand pair for one edge; returns positioned #1 after the accept edge.
  task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_out(output int cnt);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({out_valid, in_ready, mul_a, mul_b, out_p} !== {1'b0, 1'b1, 4'd0, 4'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%0b ir=%0b ma=%0h mb=%0h p=%0h, want ov=0 ir=1 ma=0 mb=0 p=0",
               out_valid, in_ready, mul_a, mul_b, out_p);
    end
    n_vec++;
    if ({s_out_valid, s_in_ready, s_mul_a, s_mul_b, s_out_p} !== {1'b0, 1'b1, 4'd0, 4'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_state_skip: got ov=%0b ir=%0b p=%0h, want ov=0 ir=1 p=0",
               s_out_valid, s_in_ready, s_out_p);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact;
    logic [3:0] ea [4] = '{4'h2, 4'h1, 4'h2, 4'h1};
    logic [3:0] eb [4] = '{4'h4, 4'h4, 4'h3, 4'h3};
    out_ready = 1'b1;
    accept_op(8'h12, 8'h34);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mul_a !== ea[i] || mul_b !== eb[i] || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL exact_pair%0d: got (%0h,%0h) ov=%0b, want (%0h,%0h) ov=0",
                 i, mul_a, mul_b, out_valid, ea[i], eb[i]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_p !== 16'h03A8 || mul_a !== 4'd0 || mul_b !== 4'd0) begin
      n_err++;
      $display("FAIL exact_product: got ov=%0b p=%0h ma=%0h mb=%0h, want ov=1 p=03a8 ma=0 mb=0",
               out_valid, out_p, mul_a, mul_b);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL exact_retire: got ov=%0b ir=%0b, want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturate;
    int cnt;
    force_ff = 1'b1;
    accept_op(8'hFF, 8'hFF);
    wait_out(cnt);
    n_vec++;
    if (cnt != 5 || out_p !== 16'hFFFF) begin
      n_err++;
      $display("FAIL saturate: got lat=%0d p=%0h, want lat=5 p=ffff", cnt, out_p);
    end
    @(posedge clk); #1;
    force_ff = 1'b0;
  endtask

  task automatic test_zero;
    int cnt;
    accept_op(8'h00, 8'h55);
    n_vec++;
    if (mul_a !== 4'd0 || mul_b !== 4'd0) begin
      n_err++;
      $display("FAIL zero_mul_idle: got (%0h,%0h), want (0,0)", mul_a, mul_b);
    end
    wait_out(cnt);
    n_vec++;
    if (cnt != 1 || out_p !== 16'h0000) begin
      n_err++;
      $display("FAIL zero_product: got lat=%0d p=%0h, want lat=1 p=0000", cnt, out_p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_skip_ll;
    int cnt;
    s_in_valid = 1'b1; s_in_a = 8'h1F; s_in_b = 8'h2F;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    n_vec++;
    if (s_mul_a !== 4'h1 || s_mul_b !== 4'hF) begin
      n_err++;
      $display("FAIL skip_first_pair: got (%0h,%0h), want (1,f)", s_mul_a, s_mul_b);
    end
    cnt = 1;
    while (!s_out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_vec++;
    if (cnt != 4 || s_out_p !== 16'h04D0) begin
      n_err++;
      $display("FAIL skip_product: got lat=%0d p=%0h, want lat=4 p=04d0", cnt, s_out_p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cnt;
    out_ready = 1'b0;
    accept_op(8'h07, 8'h09);
    wait_out(cnt);
    n_vec++;
    if (cnt != 5 || out_p !== 16'd63) begin
      n_err++;
      $display("FAIL bp_product: got lat=%0d p=%0h, want lat=5 p=003f", cnt, out_p);
    end
    // A pair offered while stalled must not be sampled.
    in_valid = 1'b1; in_a = 8'hEE; in_b = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== 16'd63) begin
        n_err++;
        $display("FAIL bp_hold%0d: got ov=%0b ir=%0b p=%0h, want ov=1 ir=0 p=003f",
                 i, out_valid, in_ready, out_p);
      end
    end
    in_a = 8'h03; in_b = 8'h05; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_comb: got ir=%0b, want ir=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || mul_a !== 4'h3 || mul_b !== 4'h5) begin
      n_err++;
      $display("FAIL b2b_accept: got ov=%0b (%0h,%0h), want ov=0 (3,5)", out_valid, mul_a, mul_b);
    end
    wait_out(cnt);
    n_vec++;
    if (cnt != 5 || out_p !== 16'h000F) begin
      n_err++;
      $display("FAIL b2b_product: got lat=%0d p=%0h, want lat=5 p=000f", cnt, out_p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midop_reset;
    int cnt;
    accept_op(8'hAB, 8'hCD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (mul_a !== 4'hB || mul_b !== 4'hC) begin
      n_err++;
      $display("FAIL rst_in_pp2: got (%0h,%0h), want (b,c)", mul_a, mul_b);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, mul_a, mul_b, out_p} !== {1'b0, 1'b1, 4'd0, 4'd0, 16'd0}) begin
      n_err++;
      $display("FAIL rst_async: got ov=%0b ir=%0b ma=%0h mb=%0h p=%0h, want ov=0 ir=1 ma=0 mb=0 p=0",
               out_valid, in_ready, mul_a, mul_b, out_p);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    n_vec++;
    if (cnt != 0) begin
      n_err++;
      $display("FAIL rst_no_output: got %0d valid cycles, want 0", cnt);
    end
    accept_op(8'h02, 8'h03);
    wait_out(cnt);
    n_vec++;
    if (cnt != 5 || out_p !== 16'h0006) begin
      n_err++;
      $display("FAIL rst_next_op: got lat=%0d p=%0h, want lat=5 p=0006", cnt, out_p);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_exact();
    test_saturate();
    test_zero();
    test_skip_ll();
    test_back_to_back();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
